mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
//  Initiator for the single-port memory access interface (valid/wr_rd/addr/wdata -> rdata/ready).
//  Accepts one burst command at a time: either write an incrementing pattern or read back N words.
//  Issues one memory access per beat, collects read data into an output stream, tracks an XOR checksum.
//  Sits between test/control logic and the memory responder; drives that responder's request side directly.
// PARAMETERS
//  WIDTH       16                 data word width; must match the responder
//  DEPTH       64                 memory depth in words; addresses wrap modulo DEPTH
//  ADDR_WIDTH  $clog2(DEPTH)      address width
//  LEN_WIDTH   ADDR_WIDTH+1       burst length field width; legal length range is 0..DEPTH
//  TIMEOUT     16                 cycles to wait for ready before aborting; must be >= 2
// PORTS
//  clk          in   1           clock, all logic on posedge
//  res          in   1           asynchronous active-high reset
//  cmd_valid    in   1           command offered
//  cmd_ready    out  1           command accepted when cmd_valid & cmd_ready at posedge
//  cmd_wr       in   1           1 = write burst, 0 = read burst
//  cmd_addr     in   ADDR_WIDTH  start address
//  cmd_len      in   LEN_WIDTH   number of beats (0 = no-op)
//  cmd_seed     in   WIDTH       write pattern seed; beat k writes cmd_seed + k (mod 2^WIDTH)
//  valid        out  1           memory request strobe
//  wr_rd        out  1           memory direction, 1 = write
//  addr         out  ADDR_WIDTH  memory address
//  wdata        out  WIDTH       memory write data
//  rdata        in   WIDTH       memory read data; valid while ready = 1
//  ready        in   1           memory response
//  rd_valid     out  1           one-cycle pulse per read beat; there is no backpressure
//  rd_data      out  WIDTH       captured read word
//  rd_last      out  1           qualifies the final read beat of the burst
//  busy         out  1           burst in progress
//  done         out  1           one-cycle pulse at burst completion or abort
//  err_timeout  out  1           sticky flag; cleared when the next command is accepted
//  checksum     out  WIDTH       XOR of all read words in the current burst; cleared on accept
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1. State returns to IDLE. Reset takes effect immediately, mid-burst included.
//  FSM states: IDLE, REQ, WAIT, FIN.
//   IDLE: cmd_ready=1. On accept, latch the command, clear checksum and err_timeout, set busy=1.
//         If len==0, go to FIN; otherwise go to REQ.
//   REQ:  valid=1 for exactly one cycle, with addr/wr_rd/wdata driven from registers. Go to WAIT.
//   WAIT: valid=0 and addr/wdata held. Timeout counter increments each cycle.
//    - ready=1: the beat completes.
//      - Read beat: rd_data<=rdata, rd_valid pulse, checksum^=rdata.
//      - Advance: addr+1 (wraps DEPTH-1 -> 0), wdata+1, remaining-1.
//      - If remaining becomes 0, go to FIN (rd_last set with the final rd_valid); else go to REQ.
//    - Counter reaches TIMEOUT with no ready: set err_timeout=1 and go to FIN. The remaining beats are dropped.
//   FIN:  done=1 and busy=0 for one cycle, then return to IDLE.
//  valid is never high for two consecutive cycles. This prevents the responder from performing a duplicate access.
//  Against the standard responder (ready registered one cycle after valid), each beat takes 2 cycles.
//  An N-beat burst takes 2N+2 cycles from accept to done.
//  ready seen in REQ or IDLE is a stale response and is ignored.
//  cmd_valid during busy is not accepted (cmd_ready=0); the command is held by the producer.
//  All registered outputs are glitch-free; no combinational path from inputs to valid or addr.
//  A read burst with len=DEPTH starting at addr A visits every address exactly once, ending at A-1 mod DEPTH.
// STRUCTURE
//  Shared package mem_pkg holds:
//   - typedef enum {IDLE,REQ,WAIT,FIN} mem_mst_state_t
//   - localparam MEM_WR=1'b1, MEM_RD=1'b0
//  One sub-module, mem_beat_ctr, holds the address/data/remaining counters with wrap.
//  The FSM and timeout logic stay in the top module.
// TESTING
//  1. Write burst: addr=5, len=4, seed=16'h00A0.
//     - Memory holds A0..A3 at addresses 5..8.
//     - Exactly 4 valid pulses; done at cycle 10 after accept; rd_valid never asserted.
//  2. Read back the same 4 words (addr=5, len=4).
//     - rd_data sequence A0,A1,A2,A3; rd_last on the 4th beat only.
//     - checksum = A0^A1^A2^A3 = 16'h0000.
//  3. Wrap: write addr=62, len=4, seed=1.
//     - mem[62]=1, mem[63]=2, mem[0]=3, mem[1]=4. Addresses above 63 are never driven.
//  4. Timeout: responder tied ready=0, read len=3.
//     - One valid pulse, err_timeout=1, done after TIMEOUT cycles, no rd_valid.
//     - A subsequent accepted command clears err_timeout.
//  5. len=0 command: no valid pulse, done 2 cycles after accept, checksum=0.
//     Also assert cmd_valid during a busy burst -> cmd_ready=0 until done.
//  6. Reset mid-burst: assert res during WAIT of beat 2.
//     - valid/busy/rd_valid drop immediately; cmd_ready=1 after release.
//     - A fresh burst completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state type and direction encodings for the memory burst master
package mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} mem_mst_state_t;
  localparam logic MEM_WR = 1'b1;
  localparam logic MEM_RD = 1'b0;
endpackage

// File: rtl/mem_beat_ctr.sv
// mem_beat_ctr: per-beat address/data/remaining counters, address wraps at DEPTH
module mem_beat_ctr #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      seed_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [LEN_WIDTH-1:0]  rem_o
);
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      data_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      data_q <= seed_i;
      rem_q  <= len_i;
    end else if (adv_i) begin
      addr_q <= addr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : addr_q + ADDR_WIDTH'(1);
      data_q <= data_q + WIDTH'(1);
      rem_q  <= rem_q - LEN_WIDTH'(1);
    end
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator for the single-port memory interface.
// One access per beat, read data streamed out with a running XOR checksum.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic [WIDTH-1:0]      checksum_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  mem_mst_state_t        state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wr_q, wr_d, err_q, err_d, rdv_q, rdv_d, rdl_q, rdl_d;
  logic [WIDTH-1:0]      chk_q, chk_d, rdd_q, rdd_d;
  logic                  valid_q, rdy_q, busy_q, done_q;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  accept, hit, last;
  assign accept = cmd_valid_i & (state_q == IDLE);
  assign hit    = ready_i & (state_q == WAIT);
  assign last   = rem == LEN_WIDTH'(1);
  mem_beat_ctr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) u_ctr (
    .clk_i(clk_i), .rst_i(res_i), .load_i(accept), .adv_i(hit),
    .addr_i(cmd_addr_i), .seed_i(cmd_seed_i), .len_i(cmd_len_i),
    .addr_o(addr_o), .data_o(wdata_o), .rem_o(rem)
  );
  // ready outside WAIT is a stale response and never advances the burst
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    wr_d    = wr_q;
    err_d   = err_q;
    chk_d   = chk_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
    rdl_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d = cmd_len_i == '0 ? FIN : REQ;
        wr_d    = cmd_wr_i;
        err_d   = 1'b0;
        chk_d   = '0;
      end
      REQ: state_d = WAIT;
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (ready_i) begin
          state_d = last ? FIN : REQ;
          if (wr_q == MEM_RD) begin
            rdv_d = 1'b1;
            rdl_d = last;
            rdd_d = rdata_i;
            chk_d = chk_q ^ rdata_i;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge res_i)
    if (res_i) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= '0;
      rdd_q   <= '0;
      rdv_q   <= 1'b0;
      rdl_q   <= 1'b0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
      rdl_q   <= rdl_d;
      valid_q <= state_d == REQ;
      rdy_q   <= state_d == IDLE;
      busy_q  <= state_d != IDLE;
      done_q  <= state_q == FIN;
    end
  assign valid_o       = valid_q;
  assign wr_rd_o       = wr_q;
  assign cmd_ready_o   = rdy_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign checksum_o    = chk_q;
  assign rd_valid_o    = rdv_q;
  assign rd_data_o     = rdd_q;
  assign rd_last_o     = rdl_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed burst vectors against a one-cycle-latency memory responder
module tb_mem_burst_master;
  localparam int W = 16, D = 64, AW = 6, LW = 7, T = 16;
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [W-1:0]  seed;
    logic          en;
    int            cyc;
    int            nv;
    int            nrd;
    logic [W-1:0]  cs;
    logic          err;
  } vec_t;
  logic clk = 1'b0, res, cmd_valid, cmd_ready, cmd_wr, valid, wr_rd, rd_valid, rd_last, busy, done, err_timeout;
  logic ready = 1'b0, resp_en;
  logic [AW-1:0] cmd_addr, addr;
  logic [LW-1:0] cmd_len;
  logic [W-1:0]  cmd_seed, wdata, rd_data, checksum;
  logic [W-1:0]  rdata = '0;
  logic [W-1:0]  mem[D] = '{default: '0};
  logic [W-1:0]  shadow[D] = '{default: '0};
  int checks = 0, errors = 0, nvalid = 0, dbl = 0;
  logic pv = 1'b0;
  logic [AW-1:0] addrq[$];
  logic [W-1:0]  rdq[$];
  logic          lastq[$];
  vec_t tv[7];

  always #5 clk = ~clk;

  mem_burst_master #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk_i(clk), .res_i(res), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .valid_o(valid), .wr_rd_o(wr_rd), .addr_o(addr), .wdata_o(wdata),
    .rdata_i(rdata), .ready_i(ready), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .rd_last_o(rd_last), .busy_o(busy), .done_o(done), .err_timeout_o(err_timeout),
    .checksum_o(checksum)
  );

  always @(posedge clk) begin
    ready <= valid & resp_en;
    if (valid) begin
      if (wr_rd) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      addrq.push_back(addr);
      if (pv) dbl++;
    end
    pv = valid;
    if (rd_valid) begin
      rdq.push_back(rd_data);
      lastq.push_back(rd_last);
    end
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic wait_done(output int c, output int bad);
    bad = 0;
    for (c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done) return;
      if (cmd_ready || !busy) bad++;
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [W-1:0] s);
    @(negedge clk);
    nvalid = 0;
    dbl = 0;
    addrq.delete();
    rdq.delete();
    lastq.delete();
    cmd_wr = wr;
    cmd_addr = a;
    cmd_len = l;
    cmd_seed = s;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, bad;
    resp_en = v.en;
    issue(v.wr, v.addr, v.len, v.seed);
    cmd_valid = 1'b0;
    wait_done(c, bad);
    chk({tag, " done_cycle"}, c, v.cyc);
    chk({tag, " busy_no_ready"}, bad, 0);
    chk({tag, " valid_pulses"}, nvalid, v.nv);
    chk({tag, " valid_back2back"}, dbl, 0);
    chk({tag, " rd_beats"}, rdq.size(), v.nrd);
    chk({tag, " checksum"}, int'(checksum), int'(v.cs));
    chk({tag, " err_timeout"}, int'(err_timeout), int'(v.err));
    foreach (addrq[k]) chk({tag, " addr"}, int'(addrq[k]), (int'(v.addr) + k) % D);
    foreach (rdq[k]) begin
      chk({tag, " rd_data"}, int'(rdq[k]), int'(shadow[(int'(v.addr) + k) % D]));
      chk({tag, " rd_last"}, int'(lastq[k]), int'(k == v.nrd - 1));
    end
    if (v.wr && v.en)
      for (int k = 0; k < int'(v.len); k++) begin
        shadow[(int'(v.addr) + k) % D] = v.seed + W'(k);
        chk({tag, " mem"}, int'(mem[(int'(v.addr) + k) % D]), int'(shadow[(int'(v.addr) + k) % D]));
      end
  endtask

  initial begin
    int c, bad;
    tv[0] = '{1'b1, 6'd5,  7'd4,  16'h00A0, 1'b1, 10,  4,  0,  16'h0000, 1'b0};
    tv[1] = '{1'b0, 6'd5,  7'd4,  16'h0000, 1'b1, 10,  4,  4,  16'h0000, 1'b0};
    tv[2] = '{1'b1, 6'd62, 7'd4,  16'h0001, 1'b1, 10,  4,  0,  16'h0000, 1'b0};
    tv[3] = '{1'b0, 6'd62, 7'd4,  16'h0000, 1'b1, 10,  4,  4,  16'h0004, 1'b0};
    tv[4] = '{1'b0, 6'd10, 7'd0,  16'h0000, 1'b1, 2,   0,  0,  16'h0000, 1'b0};
    tv[5] = '{1'b0, 6'd20, 7'd3,  16'h0000, 1'b0, T+3, 1,  0,  16'h0000, 1'b1};
    tv[6] = '{1'b0, 6'd5,  7'd64, 16'h0000, 1'b1, 130, 64, 64, 16'h0004, 1'b0};
    res = 1'b1;
    resp_en = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_seed = '0;
    repeat (2) @(negedge clk);
    chk("rst cmd_ready", int'(cmd_ready), 1);
    chk("rst valid", int'(valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst err", int'(err_timeout), 0);
    chk("rst checksum", int'(checksum), 0);
    chk("rst addr", int'(addr), 0);
    res = 1'b0;
    foreach (tv[i]) run_vec(tv[i], $sformatf("vec%0d", i));
    // command held during a busy burst must wait for the burst to finish
    resp_en = 1'b1;
    issue(1'b0, 6'd5, 7'd2, 16'h0000);
    cmd_len = '0;
    cmd_addr = 6'd30;
    wait_done(c, bad);
    chk("hold done_cycle", c, 6);
    chk("hold ready_low", bad, 0);
    chk("hold checksum", int'(checksum), 16'h0001);
    chk("hold ready_at_done", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(c, bad);
    chk("held len0 done_cycle", c, 2);
    chk("held len0 checksum", int'(checksum), 0);
    chk("held len0 valid_pulses", nvalid, 2);
    // asynchronous reset during the WAIT of beat 2
    issue(1'b0, 6'd5, 7'd4, 16'h0000);
    cmd_valid = 1'b0;
    for (c = 0; c < 50 && nvalid < 2; c++) @(negedge clk);
    chk("rst_mid reached_beat2", nvalid, 2);
    @(negedge clk);
    res = 1'b1;
    #1;
    chk("rst_mid valid", int'(valid), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid rd_valid", int'(rd_valid), 0);
    chk("rst_mid done", int'(done), 0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_mid cmd_ready", int'(cmd_ready), 1);
    chk("rst_mid busy_after", int'(busy), 0);
    run_vec(tv[3], "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
